// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: FSM states, opcode classes, opcodes and control-field encodings for multicycle_ctrl
package ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_ILLEGAL
  } state_t;
  typedef enum logic [2:0] {CLS_NONE, CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BR, CLS_JAL} cls_t;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  function automatic cls_t op_class(input logic [6:0] op);
    return op == OP_R ? CLS_R : op == OP_I ? CLS_I : op == OP_LW ? CLS_LW :
           op == OP_SW ? CLS_SW : op == OP_BR ? CLS_BR : op == OP_JAL ? CLS_JAL : CLS_NONE;
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction, memory handshake and datapath control bundle
interface multicycle_ctrl_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] instr;
  logic             EQ;
  logic             mem_ready;
  logic             mem_req;
  logic             MemWrite;
  logic             AdrSrc;
  logic             IRwrite;
  logic [2:0]       ALUctrl;
  logic             ALUsrc;
  logic [1:0]       ImmSrc;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic             PCwrite;
  logic             PCsrc;
  logic             illegal;
  modport master (
    input  instr, EQ, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRwrite, ALUctrl, ALUsrc, ImmSrc,
           RegWrite, ResultSrc, PCwrite, PCsrc, illegal
  );
  modport slave (
    output instr, EQ, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRwrite, ALUctrl, ALUsrc, ImmSrc,
           RegWrite, ResultSrc, PCwrite, PCsrc, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// alu_decoder: maps opcode class, funct3 and funct7[5] to ALUctrl and an instruction-legal bit
module alu_decoder
  import ctrl_pkg::*;
(
  input  cls_t       cls,
  input  logic [2:0] funct3,
  input  logic       f7b5,
  output logic [2:0] alu_ctrl,
  output logic       valid
);
  logic       f3_ok;
  logic [2:0] arith;
  always_comb begin
    f3_ok    = funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110 || funct3 == 3'b010;
    arith    = funct3 == 3'b111 ? ALU_AND : funct3 == 3'b110 ? ALU_OR :
               funct3 == 3'b010 ? ALU_SLT : (cls == CLS_R && f7b5) ? ALU_SUB : ALU_ADD;
    alu_ctrl = cls == CLS_BR ? ALU_SUB : (cls == CLS_R || cls == CLS_I) ? arith : ALU_ADD;
    valid    = cls == CLS_R ? f3_ok && (!f7b5 || funct3 == 3'b000) :
               cls == CLS_I ? f3_ok :
               (cls == CLS_LW || cls == CLS_SW) ? funct3 == 3'b010 :
               cls == CLS_BR ? funct3[2:1] == 2'b00 :
               cls == CLS_JAL;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I-subset multi-cycle control FSM; define ILLEGAL_TRAP_EN to trap on illegal instructions
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  multicycle_ctrl_if.master bus
);
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic [WIDTH-1:0] ir;
  logic             unused_ir;
  state_t           state;
  cls_t             cls;
  logic [2:0]       dec_alu;
  logic             dec_valid;
  logic             illegal_q;
  logic             take;
  logic             run;
  assign ir        = bus.instr;
  assign unused_ir = ^{ir[WIDTH-1:31], ir[29:15], ir[11:7]};
  assign cls       = op_class(ir[6:0]);
  assign run       = !rst;
  assign take      = ir[12] ? !bus.EQ : bus.EQ;
  alu_decoder u_dec (
    .cls      (cls),
    .funct3   (ir[14:12]),
    .f7b5     (ir[30]),
    .alu_ctrl (dec_alu),
    .valid    (dec_valid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
        S_DECODE:   state <= !dec_valid ? S_ILLEGAL : cls == CLS_R ? S_EXEC_R : cls == CLS_I ? S_EXEC_I :
                             (cls == CLS_LW || cls == CLS_SW) ? S_MEM_ADDR : cls == CLS_BR ? S_BRANCH : S_JUMP;
        S_EXEC_R:   state <= S_WB_ALU;
        S_EXEC_I:   state <= S_WB_ALU;
        S_MEM_ADDR: state <= cls == CLS_LW ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (bus.mem_ready) state <= S_WB_MEM;
        S_MEM_WR:   if (bus.mem_ready) state <= S_FETCH;
        S_ILLEGAL:  if (TRAP) illegal_q <= 1'b1; else state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end
  assign bus.mem_req   = run && (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR);
  assign bus.MemWrite  = run && state == S_MEM_WR;
  assign bus.AdrSrc    = run && (state == S_MEM_RD || state == S_MEM_WR);
  assign bus.IRwrite   = run && state == S_FETCH && bus.mem_ready;
  assign bus.ALUctrl   = !run ? ALU_ADD : (state == S_EXEC_R || state == S_EXEC_I) ? dec_alu :
                         state == S_BRANCH ? ALU_SUB : ALU_ADD;
  assign bus.ALUsrc    = run && (state == S_EXEC_I || state == S_MEM_ADDR);
  assign bus.ImmSrc    = !run ? IMM_I : (state == S_MEM_ADDR && cls == CLS_SW) ? IMM_S :
                         state == S_BRANCH ? IMM_B : state == S_JUMP ? IMM_J : IMM_I;
  assign bus.RegWrite  = run && (state == S_WB_ALU || state == S_WB_MEM || state == S_JUMP);
  assign bus.ResultSrc = !run ? RES_ALU : state == S_WB_MEM ? RES_MEM : state == S_JUMP ? RES_PC4 : RES_ALU;
  assign bus.PCwrite   = run && (state == S_WB_ALU || state == S_WB_MEM || state == S_BRANCH || state == S_JUMP ||
                         (state == S_MEM_WR && bus.mem_ready) || (state == S_ILLEGAL && !TRAP));
  assign bus.PCsrc     = run && (state == S_JUMP || (state == S_BRANCH && take));
  assign bus.illegal   = run && TRAP && (illegal_q || state == S_ILLEGAL);
endmodule
